// File: rtl/ddr_axi_arb_2x1.sv
// Two-master to one-slave AXI4 arbiter for the shared DDR port.
// Round-robin AW/AR grants, in-order W steering, ID-MSB response routing.
module ddr_axi_arb_rr (
    input  logic aclk,
    input  logic aresetn,
    input  logic req0,
    input  logic req1,
    input  logic block,
    input  logic hs,
    output logic busy,
    output logic grant
);

    typedef enum logic {IDLE, BUSY} st_t;

    st_t  st, st_n;
    logic g, g_n;
    logic rr, rr_n;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            st <= IDLE;
            g  <= 1'b0;
            rr <= 1'b0;
        end else begin
            st <= st_n;
            g  <= g_n;
            rr <= rr_n;
        end
    end

    always_comb begin
        st_n = st;
        g_n  = g;
        rr_n = rr;
        unique case (st)
            IDLE: begin
                if ((req0 || req1) && !block) begin
                    g_n  = (req0 && req1) ? rr : req1;
                    st_n = BUSY;
                end
            end
            BUSY: begin
                // Pointer moves only on the completed handshake
                if (hs) begin
                    rr_n = ~g;
                    st_n = IDLE;
                end
            end
            default: st_n = IDLE;
        endcase
    end

    assign busy  = (st == BUSY);
    assign grant = g;

endmodule

module ddr_axi_arb_2x1 #(
    parameter int ADDR_W      = 64,
    parameter int DATA_W      = 512,
    parameter int ID_W        = 5,
    parameter int WFIFO_DEPTH = 4
) (
    input  logic                aclk,
    input  logic                aresetn,
    // master 0
    input  logic                s0_awvalid,
    output logic                s0_awready,
    input  logic [ADDR_W-1:0]   s0_awaddr,
    input  logic [7:0]          s0_awlen,
    input  logic [ID_W-1:0]     s0_awid,
    input  logic                s0_wvalid,
    output logic                s0_wready,
    input  logic [DATA_W-1:0]   s0_wdata,
    input  logic [DATA_W/8-1:0] s0_wstrb,
    input  logic                s0_wlast,
    output logic                s0_bvalid,
    input  logic                s0_bready,
    output logic [ID_W-1:0]     s0_bid,
    output logic [1:0]          s0_bresp,
    input  logic                s0_arvalid,
    output logic                s0_arready,
    input  logic [ADDR_W-1:0]   s0_araddr,
    input  logic [7:0]          s0_arlen,
    input  logic [ID_W-1:0]     s0_arid,
    output logic                s0_rvalid,
    input  logic                s0_rready,
    output logic [DATA_W-1:0]   s0_rdata,
    output logic [1:0]          s0_rresp,
    output logic [ID_W-1:0]     s0_rid,
    output logic                s0_rlast,
    // master 1
    input  logic                s1_awvalid,
    output logic                s1_awready,
    input  logic [ADDR_W-1:0]   s1_awaddr,
    input  logic [7:0]          s1_awlen,
    input  logic [ID_W-1:0]     s1_awid,
    input  logic                s1_wvalid,
    output logic                s1_wready,
    input  logic [DATA_W-1:0]   s1_wdata,
    input  logic [DATA_W/8-1:0] s1_wstrb,
    input  logic                s1_wlast,
    output logic                s1_bvalid,
    input  logic                s1_bready,
    output logic [ID_W-1:0]     s1_bid,
    output logic [1:0]          s1_bresp,
    input  logic                s1_arvalid,
    output logic                s1_arready,
    input  logic [ADDR_W-1:0]   s1_araddr,
    input  logic [7:0]          s1_arlen,
    input  logic [ID_W-1:0]     s1_arid,
    output logic                s1_rvalid,
    input  logic                s1_rready,
    output logic [DATA_W-1:0]   s1_rdata,
    output logic [1:0]          s1_rresp,
    output logic [ID_W-1:0]     s1_rid,
    output logic                s1_rlast,
    // DDR side
    output logic                m_awvalid,
    input  logic                m_awready,
    output logic [ADDR_W-1:0]   m_awaddr,
    output logic [7:0]          m_awlen,
    output logic [ID_W:0]       m_awid,
    output logic                m_wvalid,
    input  logic                m_wready,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    output logic                m_wlast,
    input  logic                m_bvalid,
    output logic                m_bready,
    input  logic [ID_W:0]       m_bid,
    input  logic [1:0]          m_bresp,
    output logic                m_arvalid,
    input  logic                m_arready,
    output logic [ADDR_W-1:0]   m_araddr,
    output logic [7:0]          m_arlen,
    output logic [ID_W:0]       m_arid,
    input  logic                m_rvalid,
    output logic                m_rready,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic [1:0]          m_rresp,
    input  logic [ID_W:0]       m_rid,
    input  logic                m_rlast
);

    localparam int PW = $clog2(WFIFO_DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(WFIFO_DEPTH);

    logic aw_busy, aw_g, aw_hs;
    logic ar_busy, ar_g, ar_hs;
    logic wf_full, wf_empty, wf_head, wf_pop;
    logic [WFIFO_DEPTH-1:0] wf_mem;
    logic [PW-1:0] wf_wr, wf_rd;
    logic [PW:0] wf_cnt;
    logic bk, rk;

    ddr_axi_arb_rr u_aw (
        .aclk    (aclk),
        .aresetn (aresetn),
        .req0    (s0_awvalid),
        .req1    (s1_awvalid),
        .block   (wf_full),
        .hs      (aw_hs),
        .busy    (aw_busy),
        .grant   (aw_g)
    );

    ddr_axi_arb_rr u_ar (
        .aclk    (aclk),
        .aresetn (aresetn),
        .req0    (s0_arvalid),
        .req1    (s1_arvalid),
        .block   (1'b0),
        .hs      (ar_hs),
        .busy    (ar_busy),
        .grant   (ar_g)
    );

    assign m_awvalid  = aw_busy & (aw_g ? s1_awvalid : s0_awvalid);
    assign m_awaddr   = aw_g ? s1_awaddr : s0_awaddr;
    assign m_awlen    = aw_g ? s1_awlen : s0_awlen;
    assign m_awid     = {aw_g, aw_g ? s1_awid : s0_awid};
    assign s0_awready = aw_busy & ~aw_g & m_awready;
    assign s1_awready = aw_busy & aw_g & m_awready;
    assign aw_hs      = m_awvalid & m_awready;

    assign m_arvalid  = ar_busy & (ar_g ? s1_arvalid : s0_arvalid);
    assign m_araddr   = ar_g ? s1_araddr : s0_araddr;
    assign m_arlen    = ar_g ? s1_arlen : s0_arlen;
    assign m_arid     = {ar_g, ar_g ? s1_arid : s0_arid};
    assign s0_arready = ar_busy & ~ar_g & m_arready;
    assign s1_arready = ar_busy & ar_g & m_arready;
    assign ar_hs      = m_arvalid & m_arready;

    // Grant-order FIFO: one bit per accepted AW naming its master
    assign wf_full  = (wf_cnt == FULL_CNT);
    assign wf_empty = (wf_cnt == '0);
    assign wf_head  = wf_mem[wf_rd];
    assign wf_pop   = m_wvalid & m_wready & m_wlast;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wf_mem <= '0;
            wf_wr  <= '0;
            wf_rd  <= '0;
            wf_cnt <= '0;
        end else begin
            if (aw_hs) begin
                wf_mem[wf_wr] <= aw_g;
                wf_wr         <= wf_wr + PW'(1);
            end
            if (wf_pop)
                wf_rd <= wf_rd + PW'(1);
            if (aw_hs && !wf_pop)
                wf_cnt <= wf_cnt + (PW+1)'(1);
            else if (!aw_hs && wf_pop)
                wf_cnt <= wf_cnt - (PW+1)'(1);
        end
    end

    assign m_wvalid  = ~wf_empty & (wf_head ? s1_wvalid : s0_wvalid);
    assign m_wdata   = wf_head ? s1_wdata : s0_wdata;
    assign m_wstrb   = wf_head ? s1_wstrb : s0_wstrb;
    assign m_wlast   = wf_head ? s1_wlast : s0_wlast;
    assign s0_wready = ~wf_empty & ~wf_head & m_wready;
    assign s1_wready = ~wf_empty & wf_head & m_wready;

    assign bk        = m_bid[ID_W];
    assign s0_bvalid = m_bvalid & ~bk;
    assign s1_bvalid = m_bvalid & bk;
    assign s0_bid    = m_bid[ID_W-1:0];
    assign s1_bid    = m_bid[ID_W-1:0];
    assign s0_bresp  = m_bresp;
    assign s1_bresp  = m_bresp;
    assign m_bready  = bk ? s1_bready : s0_bready;

    assign rk        = m_rid[ID_W];
    assign s0_rvalid = m_rvalid & ~rk;
    assign s1_rvalid = m_rvalid & rk;
    assign s0_rid    = m_rid[ID_W-1:0];
    assign s1_rid    = m_rid[ID_W-1:0];
    assign s0_rdata  = m_rdata;
    assign s1_rdata  = m_rdata;
    assign s0_rresp  = m_rresp;
    assign s1_rresp  = m_rresp;
    assign s0_rlast  = m_rlast;
    assign s1_rlast  = m_rlast;
    assign m_rready  = rk ? s1_rready : s0_rready;

endmodule

// File: tb/tb_ddr_axi_arb_2x1.sv
// Directed bench for ddr_axi_arb_2x1: reset, write path, contention,
// FIFO-full back-pressure, read routing and mid-operation reset.
module tb_ddr_axi_arb_2x1;

    localparam int ADDR_W = 64;
    localparam int DATA_W = 512;
    localparam int ID_W   = 5;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;

    logic s0_awvalid, s0_awready, s1_awvalid, s1_awready;
    logic [ADDR_W-1:0] s0_awaddr, s1_awaddr, m_awaddr;
    logic [7:0] s0_awlen, s1_awlen, m_awlen;
    logic [ID_W-1:0] s0_awid, s1_awid;
    logic s0_wvalid, s0_wready, s0_wlast, s1_wvalid, s1_wready, s1_wlast;
    logic [DATA_W-1:0] s0_wdata, s1_wdata, m_wdata;
    logic [DATA_W/8-1:0] s0_wstrb, s1_wstrb, m_wstrb;
    logic s0_bvalid, s0_bready, s1_bvalid, s1_bready;
    logic [ID_W-1:0] s0_bid, s1_bid;
    logic [1:0] s0_bresp, s1_bresp;
    logic s0_arvalid, s0_arready, s1_arvalid, s1_arready;
    logic [ADDR_W-1:0] s0_araddr, s1_araddr, m_araddr;
    logic [7:0] s0_arlen, s1_arlen, m_arlen;
    logic [ID_W-1:0] s0_arid, s1_arid;
    logic s0_rvalid, s0_rready, s0_rlast, s1_rvalid, s1_rready, s1_rlast;
    logic [DATA_W-1:0] s0_rdata, s1_rdata, m_rdata;
    logic [1:0] s0_rresp, s1_rresp, m_rresp, m_bresp;
    logic [ID_W-1:0] s0_rid, s1_rid;
    logic m_awvalid, m_awready, m_wvalid, m_wready, m_wlast;
    logic m_bvalid, m_bready, m_arvalid, m_arready;
    logic m_rvalid, m_rready, m_rlast;
    logic [ID_W:0] m_awid, m_bid, m_arid, m_rid;

    int errors = 0;
    int checks = 0;
    logic got;

    always #5 aclk = ~aclk;

    ddr_axi_arb_2x1 dut (
        .aclk(aclk), .aresetn(aresetn),
        .s0_awvalid(s0_awvalid), .s0_awready(s0_awready),
        .s0_awaddr(s0_awaddr), .s0_awlen(s0_awlen), .s0_awid(s0_awid),
        .s0_wvalid(s0_wvalid), .s0_wready(s0_wready),
        .s0_wdata(s0_wdata), .s0_wstrb(s0_wstrb), .s0_wlast(s0_wlast),
        .s0_bvalid(s0_bvalid), .s0_bready(s0_bready),
        .s0_bid(s0_bid), .s0_bresp(s0_bresp),
        .s0_arvalid(s0_arvalid), .s0_arready(s0_arready),
        .s0_araddr(s0_araddr), .s0_arlen(s0_arlen), .s0_arid(s0_arid),
        .s0_rvalid(s0_rvalid), .s0_rready(s0_rready),
        .s0_rdata(s0_rdata), .s0_rresp(s0_rresp),
        .s0_rid(s0_rid), .s0_rlast(s0_rlast),
        .s1_awvalid(s1_awvalid), .s1_awready(s1_awready),
        .s1_awaddr(s1_awaddr), .s1_awlen(s1_awlen), .s1_awid(s1_awid),
        .s1_wvalid(s1_wvalid), .s1_wready(s1_wready),
        .s1_wdata(s1_wdata), .s1_wstrb(s1_wstrb), .s1_wlast(s1_wlast),
        .s1_bvalid(s1_bvalid), .s1_bready(s1_bready),
        .s1_bid(s1_bid), .s1_bresp(s1_bresp),
        .s1_arvalid(s1_arvalid), .s1_arready(s1_arready),
        .s1_araddr(s1_araddr), .s1_arlen(s1_arlen), .s1_arid(s1_arid),
        .s1_rvalid(s1_rvalid), .s1_rready(s1_rready),
        .s1_rdata(s1_rdata), .s1_rresp(s1_rresp),
        .s1_rid(s1_rid), .s1_rlast(s1_rlast),
        .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awid(m_awid),
        .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
        .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_bid(m_bid), .m_bresp(m_bresp),
        .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arid(m_arid),
        .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_rdata(m_rdata), .m_rresp(m_rresp),
        .m_rid(m_rid), .m_rlast(m_rlast)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic clear_inputs();
        {s0_awvalid, s1_awvalid, s0_wvalid, s1_wvalid} = '0;
        {s0_wlast, s1_wlast, s0_arvalid, s1_arvalid} = '0;
        {s0_bready, s1_bready, s0_rready, s1_rready} = '0;
        {m_awready, m_wready, m_bvalid, m_arready} = '0;
        {m_rvalid, m_rlast} = '0;
        s0_awaddr = '0; s1_awaddr = '0; s0_awlen = '0; s1_awlen = '0;
        s0_awid = '0; s1_awid = '0; s0_araddr = '0; s1_araddr = '0;
        s0_arlen = '0; s1_arlen = '0; s0_arid = '0; s1_arid = '0;
        s0_wdata = '0; s1_wdata = '0;
        s0_wstrb = '1; s1_wstrb = '1;
        m_bid = '0; m_bresp = '0; m_rid = '0; m_rresp = '0;
        m_rdata = '0;
    endtask

    task automatic reset_dut();
        aresetn = 1'b0;
        clear_inputs();
        step();
        step();
        aresetn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset values
        clear_inputs();
        m_awready = 1'b1;
        m_wready  = 1'b1;
        m_arready = 1'b1;
        step();
        #1;
        chk("rst_m_awvalid", m_awvalid, 0);
        chk("rst_m_wvalid", m_wvalid, 0);
        chk("rst_m_arvalid", m_arvalid, 0);
        chk("rst_aw_wready", {s0_awready, s1_awready, s0_wready, s1_wready}, 0);
        chk("rst_arready", {s0_arready, s1_arready}, 0);
        chk("rst_bvalid_rvalid", {s0_bvalid, s1_bvalid, s0_rvalid, s1_rvalid}, 0);
        reset_dut();

        // single write from s0
        m_awready = 1'b1;
        m_wready  = 1'b1;
        s0_awvalid = 1'b1;
        s0_awaddr = 64'h1000;
        s0_awlen = 8'd3;
        s0_awid = 5'd5;
        #1;
        chk("wr_aw_latency0", m_awvalid, 0);
        step();
        chk("wr_awvalid", m_awvalid, 1);
        chk("wr_awid", m_awid, 6'h05);
        chk("wr_awaddr", m_awaddr, 64'h1000);
        chk("wr_awlen", m_awlen, 3);
        chk("wr_s0_awready", s0_awready, 1);
        step();
        s0_awvalid = 1'b0;
        for (int b = 0; b < 4; b++) begin
            s0_wvalid = 1'b1;
            s0_wdata = DATA_W'(64'hD0 + b);
            s0_wlast = (b == 3);
            #1;
            chk("wr_wvalid", m_wvalid, 1);
            chk("wr_wdata", m_wdata[63:0], 64'hD0 + b);
            chk("wr_wlast", m_wlast, (b == 3));
            chk("wr_wready", {s0_wready, s1_wready}, 2'b10);
            step();
        end
        #1;
        chk("wr_fifo_empty_wready", s0_wready, 0);
        chk("wr_fifo_empty_wvalid", m_wvalid, 0);
        s0_wvalid = 1'b0;
        m_bvalid = 1'b1;
        m_bid = 6'h05;
        s0_bready = 1'b1;
        #1;
        chk("b_s0_bvalid", s0_bvalid, 1);
        chk("b_s0_bid", s0_bid, 5);
        chk("b_s1_bvalid", s1_bvalid, 0);
        chk("b_m_bready_s0", m_bready, 1);
        m_bid = 6'h25;
        #1;
        chk("b_route_s1", {s0_bvalid, s1_bvalid}, 2'b01);
        chk("b_m_bready_s1", m_bready, 0);
        m_bvalid = 1'b0;

        // contention: both request together, 4 grants
        reset_dut();
        m_awready = 1'b1;
        m_wready  = 1'b1;
        s0_awvalid = 1'b1;
        s0_awid = 5'h01;
        s1_awvalid = 1'b1;
        s1_awid = 5'h02;
        s1_wvalid = 1'b1;
        s1_wlast = 1'b1;
        s1_wdata = DATA_W'(64'hB1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("ct_awvalid", m_awvalid, 1);
            chk("ct_awid", m_awid, (i % 2) ? 6'h22 : 6'h01);
            chk("ct_s1_wready_held", s1_wready, 0);
            step();
            chk("ct_aw_gap", m_awvalid, 0);
        end
        step();
        chk("ct_full_no_grant", m_awvalid, 0);
        s0_awvalid = 1'b0;
        s1_awvalid = 1'b0;
        s0_wvalid = 1'b1;
        s0_wlast = 1'b1;
        s0_wdata = DATA_W'(64'hA0);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("ct_w_order", m_wdata[63:0], (i % 2) ? 64'hB1 : 64'hA0);
            chk("ct_s1_wready", s1_wready, (i % 2));
            step();
        end
        #1;
        chk("ct_w_drained", m_wvalid, 0);
        s0_wvalid = 1'b0;
        s1_wvalid = 1'b0;

        // FIFO full back-pressure
        reset_dut();
        m_awready = 1'b1;
        m_wready  = 1'b0;
        s1_awvalid = 1'b1;
        s1_awlen = 8'd7;
        s1_awid = 5'h03;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("ff_awvalid", m_awvalid, 1);
            if (i == 0) chk("ff_awid", m_awid, 6'h23);
            step();
        end
        chk("ff_5th_blocked", m_awvalid, 0);
        step();
        chk("ff_5th_blocked2", m_awvalid, 0);
        m_wready = 1'b1;
        for (int b = 0; b < 8; b++) begin
            s1_wvalid = 1'b1;
            s1_wlast = (b == 7);
            s1_wdata = DATA_W'(64'h100 + b);
            #1;
            chk("ff_beat", m_wdata[63:0], 64'h100 + b);
            step();
        end
        s1_wvalid = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 2 && !got; c++) begin
            step();
            if (m_awvalid) got = 1'b1;
        end
        chk("ff_regrant_2cyc", got, 1);
        s1_awvalid = 1'b0;

        // read routing to s1
        reset_dut();
        m_arready = 1'b1;
        s1_arvalid = 1'b1;
        s1_arid = 5'h1F;
        s1_araddr = 64'h2000;
        step();
        chk("rd_arvalid", m_arvalid, 1);
        chk("rd_arid", m_arid, 6'h3F);
        chk("rd_araddr", m_araddr, 64'h2000);
        chk("rd_arready", {s0_arready, s1_arready}, 2'b01);
        step();
        s1_arvalid = 1'b0;
        m_rvalid = 1'b1;
        m_rid = 6'h3F;
        m_rdata = DATA_W'(64'h11);
        s1_rready = 1'b0;
        #1;
        chk("rd_s1_rvalid", s1_rvalid, 1);
        chk("rd_s1_rid", s1_rid, 5'h1F);
        chk("rd_s0_rvalid", s0_rvalid, 0);
        chk("rd_hold", m_rready, 0);
        s1_rready = 1'b1;
        #1;
        chk("rd_beat1", m_rready, 1);
        step();
        m_rdata = DATA_W'(64'h22);
        m_rlast = 1'b1;
        s1_rready = 1'b0;
        #1;
        chk("rd_hold2", m_rready, 0);
        s1_rready = 1'b1;
        #1;
        chk("rd_beat2", {m_rready, s1_rlast}, 2'b11);
        chk("rd_data2", s1_rdata[63:0], 64'h22);
        chk("rd_s0_rvalid2", s0_rvalid, 0);
        step();
        m_rvalid = 1'b0;

        // reset while AW busy with 2 FIFO entries
        reset_dut();
        m_awready = 1'b1;
        s0_awvalid = 1'b1;
        s0_awid = 5'h04;
        step();
        step();
        step();
        step();
        m_awready = 1'b0;
        step();
        chk("mr_aw_busy", m_awvalid, 1);
        m_awready = 1'b1;
        m_wready = 1'b1;
        s0_wvalid = 1'b1;
        #1;
        chk("mr_pre_wready", {s0_awready, s0_wready}, 2'b11);
        aresetn = 1'b0;
        #1;
        chk("mr_awvalid", m_awvalid, 0);
        chk("mr_wvalid", m_wvalid, 0);
        chk("mr_readies", {s0_awready, s1_awready, s0_wready, s1_wready}, 0);
        step();
        s1_awvalid = 1'b1;
        s1_awid = 5'h06;
        aresetn = 1'b1;
        #1;
        chk("mr_fifo_empty", m_wvalid, 0);
        step();
        chk("mr_first_grant", m_awid, 6'h04);
        chk("mr_first_valid", m_awvalid, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
